// File: rtl/camsub_stream_pkg.sv
// Shared definitions for the camsub_stream block: parameter defaults and the
// per-bank fill/full state used by the ping-pong row buffers.
package camsub_stream_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned ROW_LEN_DEF = 16;
    localparam int unsigned LUT_LEN_DEF = 64;
    localparam int unsigned SUB_OFS_DEF = 50;

    // A bank is either collecting a row or holding a closed row for draining.
    typedef enum logic {
        BANK_FILL = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_e;

endpackage

// File: rtl/camsub_stream_if.sv
// Stream bundle for camsub_stream.
//   input side : in_valid/in_ready/in_data/in_last
//   output side: out_valid/out_ready/out_mv/out_sub/out_sat/out_last
//   status     : len_err (row forced closed at ROW_LEN)
// slave = the block, master = the producer/consumer around it.
interface camsub_stream_if
    import camsub_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LUT_LEN = LUT_LEN_DEF
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic signed [DATA_W-1:0]  in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [LUT_LEN-1:0]        out_mv;
    logic signed [DATA_W:0]    out_sub;
    logic                      out_sat;
    logic                      out_last;
    logic                      len_err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_mv, out_sub, out_sat, out_last, len_err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_mv, out_sub, out_sat, out_last, len_err
    );

endinterface

// File: rtl/camsub_bank.sv
// One row bank: element storage, row length, running signed max and full flag.
//   i_wr_en/i_wr_addr/i_wr_data : accepted element write
//   i_wr_close                  : this write closes the row
//   i_free                      : last element of the row left the block
//   i_rd_addr/o_rd_data         : drain read port
//   o_full/o_len/o_max          : bank status
module camsub_bank
    import camsub_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ROW_LEN = ROW_LEN_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_wr_en,
    input  logic [$clog2(ROW_LEN)-1:0]      i_wr_addr,
    input  logic signed [DATA_W-1:0]        i_wr_data,
    input  logic                            i_wr_close,
    input  logic                            i_free,
    input  logic [$clog2(ROW_LEN)-1:0]      i_rd_addr,
    output logic                            o_full,
    output logic [$clog2(ROW_LEN):0]        o_len,
    output logic signed [DATA_W-1:0]        o_max,
    output logic signed [DATA_W-1:0]        o_rd_data
);

    localparam int unsigned LW = $clog2(ROW_LEN) + 1;

    bank_state_e               r_state;
    bank_state_e               w_state_nxt;
    logic [LW-1:0]             r_len;
    logic signed [DATA_W-1:0]  r_max;
    logic signed [DATA_W-1:0]  r_mem [ROW_LEN];

    // Bank state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= BANK_FILL;
        else       r_state <= w_state_nxt;
    end

    // Fill -> full on row close, full -> fill when the row has drained
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BANK_FILL: if (i_wr_en && i_wr_close) w_state_nxt = BANK_FULL;
            BANK_FULL: if (i_free)                w_state_nxt = BANK_FILL;
            default:                              w_state_nxt = BANK_FILL;
        endcase
    end

    // Running max seeded by the first element, not by zero; length latched on close
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len <= '0;
            r_max <= '0;
        end else if (i_wr_en) begin
            if (i_wr_addr == '0 || i_wr_data > r_max) r_max <= i_wr_data;
            if (i_wr_close) r_len <= LW'(i_wr_addr) + LW'(1);
        end
    end

    // Element storage, contents need no reset
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_full    = (r_state == BANK_FULL);
    assign o_len     = r_len;
    assign o_max     = r_max;
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/camsub_stream.sv
// Streaming max-subtract stage for a CAM-based softmax: buffers each row in a
// ping-pong bank pair, tracks the row max, then replays every element as
// (xi - max) together with a one-hot LUT match vector.
//   clk, reset : clock, async active-high reset
//   s_if       : stream bundle (input elements in, match vectors out, len_err)
module camsub_stream
    import camsub_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ROW_LEN = ROW_LEN_DEF,
    parameter int unsigned LUT_LEN = LUT_LEN_DEF,
    parameter int unsigned SUB_OFS = SUB_OFS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    camsub_stream_if.slave s_if
);

    localparam int unsigned AW = $clog2(ROW_LEN);
    localparam int unsigned LW = AW + 1;
    // Wide enough to hold both the most negative difference and SUB_OFS, signed
    localparam int unsigned IW = (DATA_W + 2 > $clog2(LUT_LEN) + 2) ? DATA_W + 2
                                                                     : $clog2(LUT_LEN) + 2;

    logic                      r_wr_bank;
    logic                      r_rd_bank;
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic                      r_rd_done;
    logic                      r_len_err;
    logic                      r_out_valid;
    logic [LUT_LEN-1:0]        r_out_mv;
    logic signed [DATA_W:0]    r_out_sub;
    logic                      r_out_sat;
    logic                      r_out_last;

    logic                      w_full    [2];
    logic [LW-1:0]             w_len     [2];
    logic signed [DATA_W-1:0]  w_max     [2];
    logic signed [DATA_W-1:0]  w_rd_data [2];

    logic                      w_in_ready;
    logic                      w_in_fire;
    logic                      w_at_end;
    logic                      w_close;
    logic                      w_out_fire;
    logic                      w_load;
    logic                      w_last_elem;
    logic signed [DATA_W-1:0]  w_x;
    logic signed [DATA_W-1:0]  w_m;
    logic signed [DATA_W:0]    w_sub;
    logic signed [IW-1:0]      w_idx;
    logic                      w_sat;
    logic [LUT_LEN-1:0]        w_mv;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        camsub_bank #(
            .DATA_W  (DATA_W),
            .ROW_LEN (ROW_LEN)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .i_wr_en    (w_in_fire && (r_wr_bank == 1'(b))),
            .i_wr_addr  (r_wr_ptr),
            .i_wr_data  (s_if.in_data),
            .i_wr_close (w_close),
            .i_free     (w_out_fire && r_out_last && (r_rd_bank == 1'(b))),
            .i_rd_addr  (r_rd_ptr),
            .o_full     (w_full[b]),
            .o_len      (w_len[b]),
            .o_max      (w_max[b]),
            .o_rd_data  (w_rd_data[b])
        );
    end

    // Handshake decode; in_ready depends only on registered bank state
    assign w_in_ready  = !w_full[r_wr_bank];
    assign w_in_fire   = s_if.in_valid && w_in_ready;
    assign w_at_end    = (r_wr_ptr == AW'(ROW_LEN - 1));
    assign w_close     = w_in_fire && (s_if.in_last || w_at_end);
    assign w_out_fire  = r_out_valid && s_if.out_ready;
    // r_rd_done stops re-reading past the row end while its last element waits
    assign w_load      = w_full[r_rd_bank] && !r_rd_done && (!r_out_valid || s_if.out_ready);
    assign w_last_elem = (LW'(r_rd_ptr) == w_len[r_rd_bank] - LW'(1));

    // Difference is computed one bit wider so it can never overflow
    always_comb begin
        w_x   = w_rd_data[r_rd_bank];
        w_m   = w_max[r_rd_bank];
        w_sub = {w_x[DATA_W-1], w_x} - {w_m[DATA_W-1], w_m};
        w_idx = IW'(w_sub) + IW'(SUB_OFS);
        w_sat = (w_idx < 0);
        w_mv  = w_sat ? LUT_LEN'(1) : (LUT_LEN'(1) << w_idx);
    end

    // Write side: pointer, bank select and forced-close pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_in_fire && w_at_end && !s_if.in_last;
            if (w_in_fire) begin
                if (w_close) begin
                    r_wr_ptr  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                end
            end
        end
    end

    // Read side: output registers, drain pointer and bank hand-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_bank   <= 1'b0;
            r_rd_ptr    <= '0;
            r_rd_done   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_mv    <= '0;
            r_out_sub   <= '0;
            r_out_sat   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_mv    <= w_mv;
                r_out_sub   <= w_sub;
                r_out_sat   <= w_sat;
                r_out_last  <= w_last_elem;
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                if (w_last_elem) r_rd_done <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_fire && r_out_last) begin
                r_rd_bank <= ~r_rd_bank;
                r_rd_ptr  <= '0;
                r_rd_done <= 1'b0;
            end
        end
    end

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = r_out_valid;
    assign s_if.out_mv    = r_out_mv;
    assign s_if.out_sub   = r_out_sub;
    assign s_if.out_sat   = r_out_sat;
    assign s_if.out_last  = r_out_last;
    assign s_if.len_err   = r_len_err;

endmodule

// File: doc/camsub_stream.md
CAMSUB_STREAM -- requirements
Module: camsub_stream

Interface
REQ-001 Parameter DATA_W, default 8, signed input element width.
REQ-002 Parameter ROW_LEN, default 16, maximum elements per softmax row (≥2, power of 2).
REQ-003 Parameter LUT_LEN, default 64, one-hot match-vector width (LUT entries).
REQ-004 Parameter SUB_OFS, default 50, index of sub=0 in the LUT (SUB_OFS ≤ LUT_LEN-1).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  input element valid.
REQ-008 in_ready  out  1  block can accept an element.
REQ-009 in_data  in  DATA_W  signed element xi.
REQ-010 in_last  in  1  marks final element of a row.
REQ-011 out_valid  out  1  output element valid.
REQ-012 out_ready  in  1  consumer accepts output.
REQ-013 out_mv  out  LUT_LEN  one-hot match vector of (xi - row max).
REQ-014 out_sub  out  DATA_W+1  signed xi - max.
REQ-015 out_sat  out  1  sub fell below LUT range; clamped.
REQ-016 out_last  out  1  final element of the row.
REQ-017 len_err  out  1  one-cycle pulse: row forced closed at ROW_LEN without in_last.

Function
REQ-018 Transfers occur on valid&&ready at a rising edge (input and output sides independently).
REQ-019 Two row banks (ping-pong), each ROW_LEN×DATA_W with per-bank length, max and full flag.
REQ-020 in_ready SHALL equal !full[wr_bank]; no combinational path from out_ready to in_ready.
REQ-021 Running max SHALL load the first element of a row, then max = (xi > max) ? xi : max, signed compare.
REQ-022 A row closes on acceptance of an element with in_last=1, or of the ROW_LEN-th element; the row's full flag sets, wr_bank toggles, write pointer clears.
REQ-023 Closing at ROW_LEN with in_last=0 SHALL pulse len_err for one cycle the next cycle; the row is processed normally.
REQ-024 Drain: when full[rd_bank] and (!out_valid || out_ready), output registers load element rd_ptr of rd_bank; out_valid rises the cycle after the closing input transfer (latency 1).
REQ-025 out_sub = sign-extended xi - max, DATA_W+1 bits, never overflows, always ≤ 0.
REQ-026 idx = out_sub + SUB_OFS; if idx < 0 then idx = 0 and out_sat=1; out_mv = 1 << idx, exactly one bit set.
REQ-027 out_last SHALL be 1 on the element at position length-1; when it is transferred, full[rd_bank] clears and rd_bank toggles.
REQ-028 Output registers hold stable while out_valid && !out_ready.
REQ-029 A bank may be filled the same cycle the other drains; a freed bank is writable the cycle after its last transfer.
REQ-030 Single-element row: out_sub=0, out_mv bit SUB_OFS, out_last=1.

Reset
REQ-031 Reset clears full flags, pointers, bank selects, lengths and max registers; in_ready=1, out_valid=0, out_mv=0, out_sub=0, out_sat=0, out_last=0, len_err=0.
REQ-032 Reset mid-row or mid-drain discards all buffered data; no output after reset until a new row closes.
REQ-033 Buffer array contents need no reset.

Structure
REQ-034 DATA_W/ROW_LEN/LUT_LEN/SUB_OFS defaults and the bank-state typedef belong in the shared def package.
REQ-035 One sub-module, camsub_bank (storage, length, running max, full flag), instantiated twice.

Verification
REQ-036 Row 16×{3,-7,12,0,...,0} with in_last on 16th -> out_sub first three {-9,-19,0}, out_mv bits {41,31,50}, out_last on 16th only.
REQ-037 Row all -20 (16 elements) -> max=-20, every out_sub=0, out_mv bit 50 (checks max not seeded with 0).
REQ-038 Row {127,-128} with in_last on 2nd -> out_sub {0,-255}, second out_sat=1, out_mv bit 0.
REQ-039 Two back-to-back rows with out_ready held 0 for 40 cycles -> in_ready drops after 2nd row closes, no data lost, rows emerge in order.
REQ-040 16 elements without in_last -> len_err pulses once, out_last on 16th; reset asserted mid-drain -> out_valid=0 next cycle, in_ready=1.
